// File: rtl/writeback_stage.sv
// Registered write-back stage: one-deep skid-free output register with result select,
// load extraction and gated register-file write. Optional retire counter via WB_RETIRE_CNT_EN.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int PC_INC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] ALU_i,
  input  logic [DATA_W-1:0] Mem_i,
  input  logic [DATA_W-1:0] PC_i,
  input  logic [DATA_W-1:0] PCtarget_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [2:0]        ResultSrc_i,
  input  logic [1:0]        MemSize_i,
  input  logic              MemUnsigned_i,
  input  logic [1:0]        ByteOff_i,
  input  logic [RD_W-1:0]   Rd_i,
  input  logic              RegWrite_i,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] Result_o,
  output logic [RD_W-1:0]   Rd_o,
  output logic              RegWrite_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt_o
`endif
);

  logic              valid_q;
  logic [DATA_W-1:0] result_q;
  logic [RD_W-1:0]   rd_q;
  logic              regwrite_q;
  logic              capture;

  logic [DATA_W-1:0] byte_lane;
  logic [DATA_W-1:0] half_lane;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] link_val;
  logic [DATA_W-1:0] sel_val;

  assign ready_o = !valid_q || ready_i;
  assign capture = valid_i && ready_o && !flush_i;

  // Lanes are brought down to bit 0 first so the extension logic is lane-independent.
  assign byte_lane = Mem_i >> {ByteOff_i, 3'b000};
  assign half_lane = Mem_i >> {ByteOff_i[1], 4'b0000};
  assign link_val  = PC_i + DATA_W'(PC_INC);

  always_comb begin
    load_val = Mem_i;
    case (MemSize_i)
      2'd0: load_val = {{(DATA_W-8){byte_lane[7] & ~MemUnsigned_i}}, byte_lane[7:0]};
      2'd1: load_val = {{(DATA_W-16){half_lane[15] & ~MemUnsigned_i}}, half_lane[15:0]};
      default: load_val = Mem_i;
    endcase
  end

  always_comb begin
    sel_val = ALU_i;
    case (ResultSrc_i)
      3'd1:    sel_val = load_val;
      3'd2:    sel_val = link_val;
      3'd3:    sel_val = PCtarget_i;
      3'd4:    sel_val = Imm_i;
      default: sel_val = ALU_i;
    endcase
  end

  // Flush outranks capture; result and rd are left as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q    <= 1'b1;
      result_q   <= sel_val;
      rd_q       <= Rd_i;
      regwrite_q <= RegWrite_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign Result_o   = result_q;
  assign Rd_o       = rd_q;
  assign RegWrite_o = valid_q && regwrite_q && (rd_q != '0);

`ifdef WB_RETIRE_CNT_EN
  // A held instruction killed by flush in the same cycle is not a retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_cnt_o <= '0;
    else if (valid_q && ready_i && !flush_i)
      retire_cnt_o <= retire_cnt_o + 64'd1;
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage with hand-computed expected values.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o;
  logic [31:0] ALU_i, Mem_i, PC_i, PCtarget_i, Imm_i;
  logic [2:0]  ResultSrc_i;
  logic [1:0]  MemSize_i;
  logic        MemUnsigned_i;
  logic [1:0]  ByteOff_i;
  logic [4:0]  Rd_i;
  logic        RegWrite_i, flush_i, ready_i;
  logic        valid_o;
  logic [31:0] Result_o;
  logic [4:0]  Rd_o;
  logic        RegWrite_o;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_o;
  logic [63:0] cnt_snap;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  writeback_stage #(.DATA_W(32), .RD_W(5), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .ALU_i(ALU_i), .Mem_i(Mem_i), .PC_i(PC_i), .PCtarget_i(PCtarget_i), .Imm_i(Imm_i),
    .ResultSrc_i(ResultSrc_i), .MemSize_i(MemSize_i), .MemUnsigned_i(MemUnsigned_i),
    .ByteOff_i(ByteOff_i), .Rd_i(Rd_i), .RegWrite_i(RegWrite_i), .flush_i(flush_i),
    .ready_i(ready_i), .valid_o(valid_o), .Result_o(Result_o), .Rd_o(Rd_o),
    .RegWrite_o(RegWrite_o)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt_o(retire_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load one instruction onto the inputs; data fields not used by src stay at defaults.
  task automatic set_load(input logic [1:0] size, input logic uns, input logic [1:0] off);
    ResultSrc_i   = 3'd1;
    Mem_i         = 32'h80F07F01;
    MemSize_i     = size;
    MemUnsigned_i = uns;
    ByteOff_i     = off;
    Rd_i          = 5'd7;
    RegWrite_i    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    ALU_i = '0; Mem_i = '0; PC_i = '0; PCtarget_i = '0; Imm_i = '0;
    ResultSrc_i = '0; MemSize_i = 2'd2; MemUnsigned_i = 1'b0; ByteOff_i = '0;
    Rd_i = '0; RegWrite_i = 1'b0;
    #12;
    check_val("rst_valid", valid_o, 0);
    check_val("rst_result", Result_o, 0);
    check_val("rst_rd", Rd_o, 0);
    check_val("rst_regwrite", RegWrite_o, 0);
    check_val("rst_ready", ready_o, 1);
`ifdef WB_RETIRE_CNT_EN
    check_val("rst_cnt", retire_cnt_o, 0);
`endif
    rst_n = 1'b1;
    step();

    // back-to-back ALU then LUI
    valid_i = 1'b1; ResultSrc_i = 3'd0; ALU_i = 32'h11; Rd_i = 5'd3; RegWrite_i = 1'b1;
    step();
    check_val("b2b_alu", Result_o, 32'h11);
    check_val("b2b_valid0", valid_o, 1);
    check_val("b2b_rw0", RegWrite_o, 1);
    check_val("b2b_rd0", Rd_o, 3);
    check_val("b2b_ready0", ready_o, 1);
    ResultSrc_i = 3'd4; Imm_i = 32'hABCDE000; Rd_i = 5'd4;
    step();
    check_val("b2b_imm", Result_o, 32'hABCDE000);
    check_val("b2b_rd1", Rd_o, 4);
    check_val("b2b_ready1", ready_o, 1);

    // load extraction
    set_load(2'd0, 1'b0, 2'd1); step(); check_val("lb_off1", Result_o, 32'h0000007F);
    set_load(2'd0, 1'b0, 2'd2); step(); check_val("lb_off2", Result_o, 32'hFFFFFFF0);
    set_load(2'd0, 1'b0, 2'd0); step(); check_val("lb_off0", Result_o, 32'h00000001);
    set_load(2'd0, 1'b1, 2'd3); step(); check_val("lbu_off3", Result_o, 32'h00000080);
    set_load(2'd0, 1'b0, 2'd3); step(); check_val("lb_off3", Result_o, 32'hFFFFFF80);
    set_load(2'd1, 1'b0, 2'd2); step(); check_val("lh_off2", Result_o, 32'hFFFF80F0);
    set_load(2'd1, 1'b1, 2'd2); step(); check_val("lhu_off2", Result_o, 32'h000080F0);
    set_load(2'd1, 1'b0, 2'd3); step(); check_val("lh_off3", Result_o, 32'hFFFF80F0);
    set_load(2'd1, 1'b0, 2'd0); step(); check_val("lh_off0", Result_o, 32'h00007F01);
    set_load(2'd3, 1'b1, 2'd1); step(); check_val("lw", Result_o, 32'h80F07F01);

    // link with wrap, rd = x0
    ResultSrc_i = 3'd2; PC_i = 32'hFFFFFFFC; Rd_i = 5'd0; RegWrite_i = 1'b1;
    step();
    check_val("link_wrap", Result_o, 32'h0);
    check_val("x0_regwrite", RegWrite_o, 0);
    check_val("x0_valid", valid_o, 1);
    PC_i = 32'h100; Rd_i = 5'd1;
    step();
    check_val("link", Result_o, 32'h104);
    check_val("link_rw", RegWrite_o, 1);
    ResultSrc_i = 3'd3; PCtarget_i = 32'h2000; RegWrite_i = 1'b0;
    step();
    check_val("target", Result_o, 32'h2000);
    check_val("no_regwrite", RegWrite_o, 0);
    ResultSrc_i = 3'd7; ALU_i = 32'h5A5A; RegWrite_i = 1'b1;
    step();
    check_val("src7_alu", Result_o, 32'h5A5A);

    // backpressure
    ResultSrc_i = 3'd0; ALU_i = 32'hAAAA; Rd_i = 5'd5;
    step();
    check_val("bp_cap", Result_o, 32'hAAAA);
    ready_i = 1'b0; ALU_i = 32'hBBBB; Rd_i = 5'd6;
    step();
`ifdef WB_RETIRE_CNT_EN
    cnt_snap = retire_cnt_o;
`endif
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      check_val("bp_ready", ready_o, 0);
      check_val("bp_hold", Result_o, 32'hAAAA);
      check_val("bp_valid", valid_o, 1);
    end
`ifdef WB_RETIRE_CNT_EN
    check_val("bp_cnt_hold", retire_cnt_o, cnt_snap);
`endif
    ready_i = 1'b1;
    #1;
    check_val("bp_release_ready", ready_o, 1);
    step();
    check_val("bp_next", Result_o, 32'hBBBB);
    check_val("bp_next_rd", Rd_o, 6);
    check_val("bp_next_valid", valid_o, 1);
`ifdef WB_RETIRE_CNT_EN
    check_val("bp_cnt_inc", retire_cnt_o, cnt_snap + 64'd1);
    cnt_snap = retire_cnt_o;
`endif

    // flush kills held and incoming
    flush_i = 1'b1; ALU_i = 32'hCCCC; Rd_i = 5'd9;
    step();
    check_val("flush_valid", valid_o, 0);
    check_val("flush_rw", RegWrite_o, 0);
    check_val("flush_result", Result_o, 32'hBBBB);
    check_val("flush_rd", Rd_o, 6);
`ifdef WB_RETIRE_CNT_EN
    check_val("flush_cnt", retire_cnt_o, cnt_snap);
`endif
    flush_i = 1'b0;
    step();
    check_val("post_flush_cap", Result_o, 32'hCCCC);
    valid_i = 1'b0;
    step();
    check_val("retire_idle", valid_o, 0);
    check_val("retire_rw", RegWrite_o, 0);

    // asynchronous reset mid-stream
    valid_i = 1'b1; ALU_i = 32'h1234; Rd_i = 5'd2;
    step();
    check_val("pre_rst_valid", valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", valid_o, 0);
    check_val("arst_rw", RegWrite_o, 0);
    check_val("arst_result", Result_o, 0);
`ifdef WB_RETIRE_CNT_EN
    check_val("arst_cnt", retire_cnt_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
